// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encoding, sweep limit and status-flag bundle shared by
//               the pipelined ALU and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_AND     = 4'h2,
    OP_OR      = 4'h3,
    OP_XOR     = 4'h4,
    OP_XNOR    = 4'h5,
    OP_NAND    = 4'h6,
    OP_NOR     = 4'h7,
    OP_SHL     = 4'h8,
    OP_SHR     = 4'h9,
    OP_SRA     = 4'hA,
    OP_SLT     = 4'hB,
    OP_SLTU    = 4'hC,
    OP_ADDC    = 4'hD,
    OP_PASSA   = 4'hE,
    OP_ILLEGAL = 4'hF
  } op_e;

  localparam logic [3:0] OP_LAST_SWEEP = 4'd14;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

  // Ops whose carry output is remembered for a later ADDC.
  function automatic logic op_sets_carry(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDC, OP_SHL, OP_SHR, OP_SRA: op_sets_carry = 1'b1;
      default:                                          op_sets_carry = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU datapath: result, carry, overflow, error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             err_o
);

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("alu_core: WIDTH must be a power of two and at least 4");
  end

  logic [SHW-1:0]      w_shamt;
  logic [WIDTH:0]      w_add_ext;
  logic [WIDTH:0]      w_addc_ext;
  logic [WIDTH:0]      w_sub_ext;
  logic [WIDTH:0]      w_shl_ext;
  logic [WIDTH:0]      w_shr_ext;
  logic signed [WIDTH:0] w_sra_ext;
  logic                w_slt;
  logic                w_sign_a;
  logic                w_sign_b;

  assign w_shamt    = b_i[SHW-1:0];
  assign w_sign_a   = a_i[WIDTH-1];
  assign w_sign_b   = b_i[WIDTH-1];
  assign w_add_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign w_addc_ext = w_add_ext + {{WIDTH{1'b0}}, carry_i};
  assign w_sub_ext  = {1'b0, a_i} - {1'b0, b_i};
  // Shifts run on a one-bit-extended vector so the extra bit catches the last
  // bit shifted out (and stays 0 for a zero shift amount).
  assign w_shl_ext  = {1'b0, a_i} << w_shamt;
  assign w_shr_ext  = {a_i, 1'b0} >> w_shamt;
  assign w_sra_ext  = $signed({a_i, 1'b0}) >>> w_shamt;
  assign w_slt      = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = w_add_ext[WIDTH-1:0];
        carry_o  = w_add_ext[WIDTH];
        ovf_o    = (w_sign_a == w_sign_b) && (w_add_ext[WIDTH-1] != w_sign_a);
      end
      OP_SUB: begin
        result_o = w_sub_ext[WIDTH-1:0];
        carry_o  = w_sub_ext[WIDTH];
        ovf_o    = (w_sign_a != w_sign_b) && (w_sub_ext[WIDTH-1] != w_sign_a);
      end
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_XNOR:  result_o = ~(a_i ^ b_i);
      OP_NAND:  result_o = ~(a_i & b_i);
      OP_NOR:   result_o = ~(a_i | b_i);
      OP_SHL: begin
        result_o = w_shl_ext[WIDTH-1:0];
        carry_o  = w_shl_ext[WIDTH];
      end
      OP_SHR: begin
        result_o = w_shr_ext[WIDTH:1];
        carry_o  = w_shr_ext[0];
      end
      OP_SRA: begin
        result_o = w_sra_ext[WIDTH:1];
        carry_o  = w_sra_ext[0];
      end
      OP_SLT:   result_o = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_ADDC: begin
        result_o = w_addc_ext[WIDTH-1:0];
        carry_o  = w_addc_ext[WIDTH];
        ovf_o    = (w_sign_a == w_sign_b) && (w_addc_ext[WIDTH-1] != w_sign_a);
      end
      OP_PASSA: result_o = a_i;
      default:  err_o    = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage valid/ready pipelined ALU with sweep-mode opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic             sweep_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_op,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_err
);

  op_e              w_issue_op;
  logic             w_accept;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_core_result;
  logic             w_core_carry;
  logic             w_core_ovf;
  logic             w_core_err;

  logic             carry_q,  carry_d;
  logic [3:0]       sweep_q,  sweep_d;

  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_result_q;
  logic             s1_carry_q;
  logic             s1_ovf_q;
  logic             s1_err_q;

  logic             out_valid_q;
  op_e              out_op_q;
  logic [WIDTH-1:0] out_result_q;
  flags_t           out_flags_q;

  assign w_issue_op = sweep_en ? op_e'(sweep_q) : op_e'(in_op);
  assign w_s2_adv   = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || w_s2_adv;
  assign w_accept   = in_valid && in_ready;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (w_issue_op),
    .carry_i  (carry_q),
    .result_o (w_core_result),
    .carry_o  (w_core_carry),
    .ovf_o    (w_core_ovf),
    .err_o    (w_core_err)
  );

  // carry_q tracks the latest accepted carry producer so a back-to-back ADDC
  // sees it even while that producer is still in stage 1.
  always_comb begin
    sweep_d = sweep_q;
    carry_d = carry_q;
    if (w_accept) begin
      if (sweep_en) begin
        sweep_d = (sweep_q == OP_LAST_SWEEP) ? 4'd0 : sweep_q + 4'd1;
      end
      if (op_sets_carry(w_issue_op)) begin
        carry_d = w_core_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_q <= 1'b0;
      sweep_q <= 4'd0;
    end else begin
      carry_q <= carry_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_result_q <= '0;
      s1_carry_q  <= 1'b0;
      s1_ovf_q    <= 1'b0;
      s1_err_q    <= 1'b0;
    end else if (w_accept) begin
      s1_valid_q  <= 1'b1;
      s1_op_q     <= w_issue_op;
      s1_result_q <= w_core_result;
      s1_carry_q  <= w_core_carry;
      s1_ovf_q    <= w_core_ovf;
      s1_err_q    <= w_core_err;
    end else if (w_s2_adv) begin
      s1_valid_q  <= 1'b0;
    end
  end

  // Output stage only loads when it may advance, which keeps out_* frozen
  // while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= OP_ADD;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (w_s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_op_q          <= s1_op_q;
        out_result_q      <= s1_result_q;
        out_flags_q.carry <= s1_carry_q;
        out_flags_q.zero  <= (s1_result_q == '0);
        out_flags_q.neg   <= s1_result_q[WIDTH-1];
        out_flags_q.ovf   <= s1_ovf_q;
        out_flags_q.err   <= s1_err_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_result = out_result_q;
  assign out_carry  = out_flags_q.carry;
  assign out_zero   = out_flags_q.zero;
  assign out_neg    = out_flags_q.neg;
  assign out_ovf    = out_flags_q.ovf;
  assign out_err    = out_flags_q.err;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_op;
  logic         sweep_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_op;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;
  logic         out_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .sweep_en   (sweep_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sw, input logic last);
    int cnt;
    cnt      = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    sweep_en = sw;
    #1;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (last) in_valid = 1'b0;
  endtask

  // flg = {carry, zero, neg, ovf, err}
  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [3:0] op,
                            input logic [4:0] flg);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"},   {24'd0, out_result}, {24'd0, r});
    check({tag, "_op"},    {28'd0, out_op}, {28'd0, op});
    check({tag, "_flags"}, {27'd0, out_carry, out_zero, out_neg, out_ovf, out_err}, {27'd0, flg});
    @(negedge clk);
  endtask

  logic [W-1:0] sw_res [16];
  logic [4:0]   sw_flg [16];
  logic [3:0]   sw_op  [16];

  initial begin
    sw_res = '{8'hFF, 8'hE1, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00,
               8'h00, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hF0, 8'hFF};
    sw_flg = '{5'b00100, 5'b00100, 5'b01000, 5'b00100, 5'b00100, 5'b01000, 5'b00100, 5'b01000,
               5'b01000, 5'b10000, 5'b10100, 5'b00000, 5'b01000, 5'b11000, 5'b00100, 5'b00100};
    sw_op  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
               4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 4'd0;
    sweep_en  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, out_result}, 32'd0);
    check("rst_flags", {27'd0, out_carry, out_zero, out_neg, out_ovf, out_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD with latency check
    send(4'd0, 8'hC8, 8'h64, 1'b0, 1'b1);
    check("add_lat_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("add_lat", {31'd0, out_valid}, 32'd1);
    expect_out("add", 8'h2C, 4'd0, 5'b10000);

    send(4'd1, 8'h05, 8'h07, 1'b0, 1'b1);
    expect_out("sub_borrow", 8'hFE, 4'd1, 5'b10100);
    send(4'd0, 8'h7F, 8'h01, 1'b0, 1'b1);
    expect_out("add_ovf", 8'h80, 4'd0, 5'b00110);

    // ADD then back-to-back ADDC picking up the in-flight carry
    send(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    send(4'd13, 8'h00, 8'h00, 1'b0, 1'b1);
    expect_out("add_wrap", 8'h00, 4'd0, 5'b11000);
    expect_out("addc_b2b", 8'h01, 4'd13, 5'b00000);

    send(4'd8, 8'h01, 8'h07, 1'b0, 1'b1);
    expect_out("shl7", 8'h80, 4'd8, 5'b00100);
    send(4'd9, 8'h81, 8'h01, 1'b0, 1'b1);
    expect_out("shr1", 8'h40, 4'd9, 5'b10000);
    send(4'd10, 8'h81, 8'h01, 1'b0, 1'b1);
    expect_out("sra1", 8'hC0, 4'd10, 5'b10100);
    send(4'd11, 8'hFF, 8'h01, 1'b0, 1'b1);
    expect_out("slt", 8'h01, 4'd11, 5'b00000);
    send(4'd12, 8'hFF, 8'h01, 1'b0, 1'b1);
    expect_out("sltu", 8'h00, 4'd12, 5'b01000);
    send(4'd1, 8'h80, 8'h01, 1'b0, 1'b1);
    expect_out("sub_ovf", 8'h7F, 4'd1, 5'b00010);

    // Illegal op must leave carry_q alone
    send(4'd0, 8'hFF, 8'h01, 1'b0, 1'b1);
    expect_out("add_setc", 8'h00, 4'd0, 5'b11000);
    send(4'd15, 8'h12, 8'h34, 1'b0, 1'b1);
    expect_out("illegal", 8'h00, 4'd15, 5'b01001);
    send(4'd13, 8'h00, 8'h00, 1'b0, 1'b1);
    expect_out("addc_keep", 8'h01, 4'd13, 5'b00000);

    // Sweep: 16 streamed beats
    fork
      begin
        for (int i = 0; i < 16; i++) send(4'd0, 8'hF0, 8'h0F, 1'b1, (i == 15));
      end
      begin
        for (int j = 0; j < 16; j++)
          expect_out($sformatf("sweep%0d", j), sw_res[j], sw_op[j], sw_flg[j]);
      end
    join
    sweep_en = 1'b0;

    // Backpressure: four beats against a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        send(4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        send(4'd0, 8'h02, 8'h02, 1'b0, 1'b0);
        send(4'd0, 8'h03, 8'h03, 1'b0, 1'b0);
        send(4'd0, 8'h04, 8'h04, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          check("bp_hold_res", {24'd0, out_result}, 32'h02);
          @(negedge clk);
        end
        out_ready = 1'b1;
        expect_out("bp0", 8'h02, 4'd0, 5'b00000);
        expect_out("bp1", 8'h04, 4'd0, 5'b00000);
        expect_out("bp2", 8'h06, 4'd0, 5'b00000);
        expect_out("bp3", 8'h08, 4'd0, 5'b00000);
      end
    join

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(4'd0, 8'h80, 8'h80, 1'b0, 1'b0);
    send(4'd0, 8'h01, 8'h01, 1'b0, 1'b1);
    check("pre_rst_carry", {31'd0, out_carry}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_res", {24'd0, out_result}, 32'd0);
    check("mid_rst_flags", {27'd0, out_carry, out_zero, out_neg, out_ovf, out_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_stale", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    send(4'd13, 8'h00, 8'h00, 1'b0, 1'b1);
    expect_out("addc_after_rst", 8'h00, 4'd13, 5'b01000);
    send(4'd0, 8'h01, 8'h02, 1'b1, 1'b1);
    expect_out("sweep_after_rst", 8'h03, 4'd0, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
